swap_sort_ctrl: RTL

- Sequencer that owns a small N-entry byte buffer and drives the two-way swap mux as a compare-and-swap (CAS) unit to bubble-sort the buffer.
- Words are loaded serially through a valid/ready input, sorted in a fixed number of cycles, then streamed out through a valid/ready output.
- The block sits between a byte producer and a consumer in the CA datapath. It is the only driver of the swap mux select.

---
 rtl/sort_pkg.sv | 24 ++
 rtl/cas_unit.sv | 30 +++
 rtl/swap_mux.sv | 19 +
 rtl/swap_sort_ctrl.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared types, default sizes and compare direction for the swap sort controller.
// SORT_DESC_EN selects descending order; the default build sorts ascending.
package sort_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int N_DEF      = 4;
    localparam int IDX_W_DEF  = 2;

    typedef enum logic [1:0] {
        StLoad  = 2'd0,
        StSort  = 2'd1,
        StDrain = 2'd2
    } state_e;

    // True when the pair must be exchanged; equal operands never swap, keeping the sort stable.
    function automatic logic cas_swap(input logic [31:0] first, input logic [31:0] second);
`ifdef SORT_DESC_EN
        return first < second;
`else
        return first > second;
`endif
    endfunction

endpackage

// File: rtl/cas_unit.sv
// Compare-and-swap: comparator driving the swap mux select; lo_o goes to the lower slot.
// Direction follows SORT_DESC_EN through sort_pkg::cas_swap.
module cas_unit import sort_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] x_i,
    input  logic [DATA_W-1:0] y_i,
    output logic [DATA_W-1:0] lo_o,
    output logic [DATA_W-1:0] hi_o
);

    logic sel;

    always_comb begin
        sel = cas_swap(32'(x_i), 32'(y_i));
    end

    swap_mux #(
        .DATA_W (DATA_W)
    ) u_swap_mux (
        .a     (x_i),
        .b     (y_i),
        .c     (x_i),
        .d     (y_i),
        .sel   (sel),
        .out_1 (lo_o),
        .out_2 (hi_o)
    );

endmodule

// File: rtl/swap_mux.sv
// Two-way swap mux: passes (a, d) straight through or crosses to (b, c) when sel is set.
module swap_mux #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c,
    input  logic [DATA_W-1:0] d,
    input  logic              sel,
    output logic [DATA_W-1:0] out_1,
    output logic [DATA_W-1:0] out_2
);

    always_comb begin
        out_1 = sel ? b : a;
        out_2 = sel ? c : d;
    end

endmodule

// File: rtl/swap_sort_ctrl.sv
// Load / fixed-latency bubble sort / drain sequencer around an N-entry buffer and one CAS unit.
// Build with SORT_DESC_EN defined for descending order; ports and timing are unchanged.
module swap_sort_ctrl import sort_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int N      = N_DEF,
    parameter int IDX_W  = IDX_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    localparam logic [IDX_W-1:0] IdxOne   = IDX_W'(1);
    localparam logic [IDX_W-1:0] LastIdx  = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] LastStep = IDX_W'(N - 2);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] mem_q [N];
    logic [DATA_W-1:0] mem_d [N];
    logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
    logic [IDX_W-1:0]  pass_q, pass_d;
    logic [IDX_W-1:0]  pair_q, pair_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    logic [IDX_W-1:0]  pair_nxt;
    logic [DATA_W-1:0] cas_lo, cas_hi;
    logic              fire_in, fire_out;

    assign pair_nxt = pair_q + IdxOne;

    cas_unit #(
        .DATA_W (DATA_W)
    ) u_cas_unit (
        .x_i  (mem_q[pair_q]),
        .y_i  (mem_q[pair_nxt]),
        .lo_o (cas_lo),
        .hi_o (cas_hi)
    );

    always_comb begin
        state_d  = state_q;
        mem_d    = mem_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        pass_d   = pass_q;
        pair_d   = pair_q;
        fire_in  = (state_q == StLoad) && in_ready_q && in_valid;
        fire_out = (state_q == StDrain) && out_valid_q && out_ready;

        unique case (state_q)
            StLoad: begin
                if (fire_in) begin
                    mem_d[wr_idx_q] = in_data;
                    if (wr_idx_q == LastIdx) begin
                        wr_idx_d = '0;
                        pass_d   = '0;
                        pair_d   = '0;
                        state_d  = StSort;
                    end else begin
                        wr_idx_d = wr_idx_q + IdxOne;
                    end
                end
            end
            StSort: begin
                mem_d[pair_q]   = cas_lo;
                mem_d[pair_nxt] = cas_hi;
                // Every pass walks all pairs so latency never depends on the data.
                if (pair_q == LastStep) begin
                    pair_d = '0;
                    if (pass_q == LastStep) begin
                        pass_d  = '0;
                        state_d = StDrain;
                    end else begin
                        pass_d = pass_q + IdxOne;
                    end
                end else begin
                    pair_d = pair_nxt;
                end
            end
            StDrain: begin
                if (fire_out) begin
                    if (rd_idx_q == LastIdx) begin
                        rd_idx_d = '0;
                        state_d  = StLoad;
                    end else begin
                        rd_idx_d = rd_idx_q + IdxOne;
                    end
                end
            end
            default: state_d = StLoad;
        endcase

        in_ready_d  = (state_d == StLoad);
        busy_d      = (state_d == StSort);
        // First DRAIN cycle settles out_data from the final buffer before valid is raised.
        out_valid_d = (state_q == StDrain) && (state_d == StDrain);
        out_data_d  = (state_q == StDrain) ? mem_q[rd_idx_d] : out_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StLoad;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            pass_q      <= '0;
            pair_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            mem_q       <= mem_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            pass_q      <= pass_d;
            pair_q      <= pair_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            out_data_q  <= out_data_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_data  = out_data_q;

endmodule
